// File: rtl/audio_gain_stage.sv
// Stereo gain stage: captures a sample pair on tick_in, optionally mixes it to mono,
// applies a per-channel Q1.15 gain with saturation and emits the result with valid_out.
module audio_gain_stage #(
    parameter int DATA_WIDTH = 24,
    parameter int GAIN_WIDTH = 16,
    parameter int GAIN_FRAC  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_in,
    input  logic [DATA_WIDTH-1:0] audio0_in,
    input  logic [DATA_WIDTH-1:0] audio1_in,
    input  logic                  cfg_in,
    input  logic [31:0]           cfg_reg_in,
    input  logic                  level_in,
    input  logic [31:0]           level_reg_in,
    input  logic                  clr_in,
    output logic [DATA_WIDTH-1:0] audio0_out,
    output logic [DATA_WIDTH-1:0] audio1_out,
    output logic                  valid_out,
    output logic                  busy_out,
    output logic                  overrun_out
);
    // state   | meaning
    // IDLE    | waiting for tick_in
    // CAPTURE | sample pair and mode/gain snapshot registered
    // MIX     | optional mono mix applied
    // SCALE   | gain and saturation applied
    // OUT     | outputs updated, valid_out high
    typedef enum logic [2:0] {IDLE, CAPTURE, MIX, SCALE, OUT} state_t;

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1) << GAIN_FRAC;
    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    state_t                 state;
    logic                   mode_mono, mode_mute;
    logic [GAIN_WIDTH-1:0]  gain0, gain1;
    logic                   snap_mono, snap_mute;
    logic [GAIN_WIDTH-1:0]  snap_gain0, snap_gain1;
    logic [DATA_WIDTH-1:0]  smp0, smp1;
    logic [DATA_WIDTH-1:0]  mono;
    logic signed [DATA_WIDTH:0] sum;
    logic                   unused_cfg;

    assign unused_cfg = ^cfg_reg_in[31:2];

    always_comb begin
        sum  = $signed({smp0[DATA_WIDTH-1], smp0}) + $signed({smp1[DATA_WIDTH-1], smp1});
        mono = DATA_WIDTH'(sum >>> 1);
    end

    function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] s,
                                                     input logic [GAIN_WIDTH-1:0] g);
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] r;
        p = $signed(s) * $signed({1'b0, g});
        r = p >>> GAIN_FRAC;
        if (r > SAT_MAX)      scale = SAT_MAX[DATA_WIDTH-1:0];
        else if (r < SAT_MIN) scale = SAT_MIN[DATA_WIDTH-1:0];
        else                  scale = r[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_mono   <= 1'b0;
            mode_mute   <= 1'b0;
            gain0       <= UNITY;
            gain1       <= UNITY;
            snap_mono   <= 1'b0;
            snap_mute   <= 1'b0;
            snap_gain0  <= UNITY;
            snap_gain1  <= UNITY;
            smp0        <= '0;
            smp1        <= '0;
            audio0_out  <= '0;
            audio1_out  <= '0;
            valid_out   <= 1'b0;
            busy_out    <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            // Register writes are independent of the datapath and of clr_in.
            if (cfg_in) begin
                mode_mono <= cfg_reg_in[0];
                mode_mute <= cfg_reg_in[1];
            end
            if (level_in) begin
                gain0 <= level_reg_in[GAIN_WIDTH-1:0];
                gain1 <= level_reg_in[16+GAIN_WIDTH-1:16];
            end
            valid_out <= 1'b0;
            if (clr_in) begin
                state       <= IDLE;
                audio0_out  <= '0;
                audio1_out  <= '0;
                busy_out    <= 1'b0;
                overrun_out <= 1'b0;
            end else begin
                if (tick_in && state != IDLE)
                    overrun_out <= 1'b1;
                case (state)
                    IDLE: if (tick_in) begin
                        smp0       <= audio0_in;
                        smp1       <= audio1_in;
                        snap_mono  <= mode_mono;
                        snap_mute  <= mode_mute;
                        snap_gain0 <= gain0;
                        snap_gain1 <= gain1;
                        busy_out   <= 1'b1;
                        state      <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (snap_mono) begin
                            smp0 <= mono;
                            smp1 <= mono;
                        end
                        state <= MIX;
                    end
                    MIX: begin
                        smp0  <= scale(smp0, snap_gain0);
                        smp1  <= scale(smp1, snap_gain1);
                        state <= SCALE;
                    end
                    SCALE: begin
                        audio0_out <= snap_mute ? '0 : smp0;
                        audio1_out <= snap_mute ? '0 : smp1;
                        valid_out  <= 1'b1;
                        state      <= OUT;
                    end
                    OUT: begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_gain_stage.sv
// Directed-vector bench for audio_gain_stage with hand-computed expectations.
module tb_audio_gain_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_in;
    logic [23:0] audio0_in, audio1_in;
    logic        cfg_in;
    logic [31:0] cfg_reg_in;
    logic        level_in;
    logic [31:0] level_reg_in;
    logic        clr_in;
    logic [23:0] audio0_out, audio1_out;
    logic        valid_out, busy_out, overrun_out;

    int errors = 0;
    int checks = 0;

    audio_gain_stage dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick_in),
        .audio0_in(audio0_in), .audio1_in(audio1_in),
        .cfg_in(cfg_in), .cfg_reg_in(cfg_reg_in),
        .level_in(level_in), .level_reg_in(level_reg_in),
        .clr_in(clr_in),
        .audio0_out(audio0_out), .audio1_out(audio1_out),
        .valid_out(valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_level(input logic [31:0] v);
        level_reg_in = v; level_in = 1'b1;
        step();
        level_in = 1'b0;
    endtask

    task automatic set_cfg(input logic [31:0] v);
        cfg_reg_in = v; cfg_in = 1'b1;
        step();
        cfg_in = 1'b0;
    endtask

    // Drives one tick and observes six cycles; records only, the callers compare.
    task automatic do_sample(input logic [23:0] a0, input logic [23:0] a1,
                             output logic [23:0] o0, output logic [23:0] o1,
                             output int vcycle, output int nvalid, output int nbusy);
        o0 = 'x; o1 = 'x; vcycle = -1; nvalid = 0; nbusy = 0;
        audio0_in = a0; audio1_in = a1; tick_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            tick_in = 1'b0;
            if (valid_out) begin
                nvalid++; vcycle = k; o0 = audio0_out; o1 = audio1_out;
            end
            if (busy_out) nbusy++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tick_in = 0; audio0_in = 0; audio1_in = 0;
        cfg_in = 0; cfg_reg_in = 0; level_in = 0; level_reg_in = 0; clr_in = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({audio0_out, audio1_out, valid_out, busy_out, overrun_out} !== 51'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h/%h v=%b b=%b o=%b required all zero",
                     audio0_out, audio1_out, valid_out, busy_out, overrun_out);
        end
    endtask

    task automatic test_unity;
        logic [23:0] o0, o1; int vc, nv, nb;
        do_sample(24'h100000, 24'hF00000, o0, o1, vc, nv, nb);
        checks++;
        if (vc !== 4 || nv !== 1) begin
            errors++; $display("FAIL unity_latency: valid at %0d count %0d, required 4 and 1", vc, nv);
        end
        checks++;
        if (o0 !== 24'h100000 || o1 !== 24'hF00000) begin
            errors++; $display("FAIL unity_data: got %h/%h required 100000/f00000", o0, o1);
        end
        checks++;
        if (nb !== 4) begin
            errors++; $display("FAIL unity_busy: busy cycles %0d required 4", nb);
        end
        checks++;
        if (audio0_out !== 24'h100000 || audio1_out !== 24'hF00000) begin
            errors++; $display("FAIL unity_hold: got %h/%h required 100000/f00000", audio0_out, audio1_out);
        end
    endtask

    task automatic test_gain;
        logic [23:0] o0, o1; int vc, nv, nb;
        set_level(32'h20004000);
        do_sample(24'h100000, 24'h100000, o0, o1, vc, nv, nb);
        checks++;
        if (o0 !== 24'h080000 || o1 !== 24'h040000 || nv !== 1) begin
            errors++; $display("FAIL per_channel_gain: got %h/%h n=%0d required 080000/040000 n=1", o0, o1, nv);
        end
    endtask

    task automatic test_saturation;
        logic [23:0] o0, o1; int vc, nv, nb;
        set_level(32'hFFFFFFFF);
        do_sample(24'h600000, 24'hA00000, o0, o1, vc, nv, nb);
        checks++;
        if (o0 !== 24'h7FFFFF || o1 !== 24'h800000) begin
            errors++; $display("FAIL saturation: got %h/%h required 7fffff/800000", o0, o1);
        end
        set_cfg(32'h2);
        do_sample(24'h600000, 24'hA00000, o0, o1, vc, nv, nb);
        checks++;
        if (o0 !== 24'h0 || o1 !== 24'h0 || vc !== 4 || nv !== 1) begin
            errors++; $display("FAIL mute: got %h/%h valid at %0d n=%0d required 0/0 at 4 n=1", o0, o1, vc, nv);
        end
        set_cfg(32'h0);
    endtask

    task automatic test_mono;
        logic [23:0] o0, o1; int vc, nv, nb;
        set_level(32'h80008000);
        set_cfg(32'hFFFFFFFD);
        do_sample(24'h000010, 24'h000003, o0, o1, vc, nv, nb);
        checks++;
        if (o0 !== 24'h000009 || o1 !== 24'h000009) begin
            errors++; $display("FAIL mono_mix: got %h/%h required 000009/000009", o0, o1);
        end
        do_sample(24'hFFFFFF, 24'h000000, o0, o1, vc, nv, nb);
        checks++;
        if (o0 !== 24'hFFFFFF || o1 !== 24'hFFFFFF) begin
            errors++; $display("FAIL mono_floor: got %h/%h required ffffff/ffffff", o0, o1);
        end
        set_cfg(32'h0);
    endtask

    task automatic test_overrun_snapshot;
        logic [23:0] o0, o1; int vc, nv, nb;
        int nvalid = 0; int vcyc = -1;
        logic [23:0] v0 = 'x, v1 = 'x;
        audio0_in = 24'h100000; audio1_in = 24'h100000; tick_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            tick_in = 1'b0; level_in = 1'b0;
            if (k == 1) begin
                level_reg_in = 32'h40004000; level_in = 1'b1;
            end
            if (k == 2) begin
                audio0_in = 24'h7FFFFF; audio1_in = 24'h7FFFFF; tick_in = 1'b1;
                checks++;
                if (overrun_out !== 1'b0) begin
                    errors++; $display("FAIL overrun_early: got %b required 0", overrun_out);
                end
            end
            if (k == 3) begin
                checks++;
                if (overrun_out !== 1'b1) begin
                    errors++; $display("FAIL overrun_set: got %b required 1", overrun_out);
                end
            end
            if (valid_out) begin
                nvalid++; vcyc = k; v0 = audio0_out; v1 = audio1_out;
            end
        end
        checks++;
        if (nvalid !== 1 || vcyc !== 4) begin
            errors++; $display("FAIL overrun_single_valid: count %0d at %0d required 1 at 4", nvalid, vcyc);
        end
        checks++;
        if (v0 !== 24'h100000 || v1 !== 24'h100000) begin
            errors++; $display("FAIL snapshot_gain: got %h/%h required 100000/100000", v0, v1);
        end
        do_sample(24'h100000, 24'h100000, o0, o1, vc, nv, nb);
        checks++;
        if (o0 !== 24'h080000 || o1 !== 24'h080000) begin
            errors++; $display("FAIL new_gain: got %h/%h required 080000/080000", o0, o1);
        end
        checks++;
        if (overrun_out !== 1'b1) begin
            errors++; $display("FAIL overrun_sticky: got %b required 1", overrun_out);
        end
    endtask

    task automatic test_clear;
        logic [23:0] o0, o1; int vc, nv, nb;
        int nvalid = 0;
        audio0_in = 24'h200000; audio1_in = 24'h200000; tick_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            tick_in = 1'b0; clr_in = 1'b0;
            if (k == 2) clr_in = 1'b1;
            if (k == 3) begin
                checks++;
                if (audio0_out !== 24'h0 || audio1_out !== 24'h0 || busy_out !== 1'b0 || overrun_out !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_state: got %h/%h busy=%b ovr=%b required 0/0 busy=0 ovr=0",
                             audio0_out, audio1_out, busy_out, overrun_out);
                end
            end
            if (valid_out) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin
            errors++; $display("FAIL clear_no_valid: count %0d required 0", nvalid);
        end
        do_sample(24'h100000, 24'h100000, o0, o1, vc, nv, nb);
        checks++;
        if (o0 !== 24'h080000 || o1 !== 24'h080000 || nv !== 1) begin
            errors++; $display("FAIL clear_keeps_gain: got %h/%h n=%0d required 080000/080000 n=1", o0, o1, nv);
        end
        nvalid = 0;
        audio0_in = 24'h300000; tick_in = 1'b1; clr_in = 1'b1;
        step();
        tick_in = 1'b0; clr_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0) begin
            errors++; $display("FAIL clear_with_tick_busy: got %b required 0", busy_out);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            if (valid_out) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin
            errors++; $display("FAIL clear_with_tick_valid: count %0d required 0", nvalid);
        end
    endtask

    task automatic test_reset_midop;
        logic [23:0] o0, o1; int vc, nv, nb;
        int nvalid = 0;
        audio0_in = 24'h100000; audio1_in = 24'h100000; tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_out !== 1'b0 || valid_out !== 1'b0 || audio0_out !== 24'h0) begin
            errors++; $display("FAIL reset_midop: busy=%b valid=%b out0=%h required 0/0/0", busy_out, valid_out, audio0_out);
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (valid_out) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin
            errors++; $display("FAIL reset_midop_no_valid: count %0d required 0", nvalid);
        end
        do_sample(24'h100000, 24'h100000, o0, o1, vc, nv, nb);
        checks++;
        if (o0 !== 24'h100000 || o1 !== 24'h100000) begin
            errors++; $display("FAIL reset_restores_unity: got %h/%h required 100000/100000", o0, o1);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_gain();
        test_saturation();
        test_mono();
        test_overrun_snapshot();
        test_clear();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
